// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, FSM encoding and round helper functions.
package sha256_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    localparam logic [255:0] H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round_logic.sv
// rtl/sha256_round_logic.sv - combinational single SHA-256 round, {a..h},W,K -> {a'..h'}.
module sha256_round_logic (
    input  logic [255:0] state_in,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] state_out
);
    import sha256_pkg::*;

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;
    assign t1 = h + big_s1(e) + ch(e, f, g) + k + w;
    assign t2 = big_s0(a) + maj(a, b, c);
    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_round_consumer.sv
// rtl/sha256_round_consumer.sv - iterative SHA-256 round engine consuming schedule windows.
// SHA256_FEEDFORWARD_EN adds the initial state back into the digest.
module sha256_round_consumer #(
    parameter int FIRST_ROUND = 0,
    parameter int LAST_ROUND  = 63
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic         win_valid,
    input  logic [511:0] win_in,
    output logic         win_ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest,
    output logic [5:0]   round_idx
);
    import sha256_pkg::*;

    generate
        if (FIRST_ROUND < 0 || FIRST_ROUND > LAST_ROUND || LAST_ROUND > 63) begin : g_bad_range
            $error("sha256_round_consumer: illegal FIRST_ROUND/LAST_ROUND range");
        end
    endgenerate

    localparam logic [5:0] FIRST_IDX = 6'(FIRST_ROUND);
    localparam logic [5:0] LAST_IDX  = 6'(LAST_ROUND);

    logic [1:0]   state_q, state_d;
    logic [5:0]   round_idx_q, round_idx_d;
    logic [255:0] work_q, work_d;
    logic [255:0] digest_q, digest_d;
    logic [255:0] round_out;
    logic [255:0] result;
    logic         win_unused;

    // Only the oldest word of the window feeds this round.
    assign win_unused = ^win_in[479:0];

    sha256_round_logic u_round (
        .state_in  (work_q),
        .w         (win_in[511:480]),
        .k         (K[round_idx_q]),
        .state_out (round_out)
    );

`ifdef SHA256_FEEDFORWARD_EN
    logic [255:0] h_save_q, h_save_d;

    always_comb begin
        h_save_d = h_save_q;
        if (state_q == IDLE && start) begin
            h_save_d = h_in;
        end
        for (int i = 0; i < 8; i++) begin
            result[32*i +: 32] = work_q[32*i +: 32] + h_save_q[32*i +: 32];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            h_save_q <= '0;
        end else begin
            h_save_q <= h_save_d;
        end
    end
`else
    assign result = work_q;
`endif

    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        work_d      = work_q;
        digest_d    = digest_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d      = h_in;
                    round_idx_d = FIRST_IDX;
                    state_d     = ROUND;
                end
            end
            ROUND: begin
                if (win_valid) begin
                    work_d = round_out;
                    if (round_idx_q == LAST_IDX) begin
                        state_d = FINAL;
                    end else begin
                        round_idx_d = round_idx_q + 6'd1;
                    end
                end
            end
            FINAL: begin
                digest_d = result;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            round_idx_q <= FIRST_IDX;
            work_q      <= '0;
            digest_q    <= '0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            work_q      <= work_d;
            digest_q    <= digest_d;
        end
    end

    assign win_ready = (state_q == ROUND);
    assign busy      = (state_q == ROUND);
    assign done      = (state_q == FINAL);
    // Bypass so the new digest is already visible during the done cycle.
    assign digest    = done ? result : digest_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_sha256_round_consumer.sv
// tb/tb_sha256_round_consumer.sv - directed bench for sha256_round_consumer.
module tb_sha256_round_consumer;
    import sha256_pkg::*;

    localparam logic [255:0] ABC_DIGEST = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [479:0] FILLER = {15{32'h5a5aa5a5}};

    logic         CLK, RST;
    logic         start0, win_valid0, win_ready0, busy0, done0;
    logic [255:0] h_in0, digest0;
    logic [511:0] win_in0;
    logic [5:0]   round_idx0;
    logic         start1, win_valid1, win_ready1, busy1, done1;
    logic [255:0] h_in1, digest1;
    logic [511:0] win_in1;
    logic [5:0]   round_idx1;

    int           checks, errors, gcyc;
    logic [31:0]  w_abc [64];
    logic [255:0] exp_abc, st, st32, exp_seg, dg;
    int           fd, nd, ns, d1, d2, n1, t, cyc;
    logic         acc;

    sha256_round_consumer #(.FIRST_ROUND(0), .LAST_ROUND(63)) u_full (
        .CLK(CLK), .RST(RST), .start(start0), .h_in(h_in0), .win_valid(win_valid0),
        .win_in(win_in0), .win_ready(win_ready0), .busy(busy0), .done(done0),
        .digest(digest0), .round_idx(round_idx0));

    sha256_round_consumer #(.FIRST_ROUND(32), .LAST_ROUND(56)) u_seg (
        .CLK(CLK), .RST(RST), .start(start1), .h_in(h_in1), .win_valid(win_valid1),
        .win_in(win_in1), .win_ready(win_ready1), .busy(busy1), .done(done1),
        .digest(digest1), .round_idx(round_idx1));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) | (~e & g)) + k + w;
        t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) | (c & (a | b)));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y, input bit sub);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = sub ? x[32*i +: 32] - y[32*i +: 32] : x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        gcyc++;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Runs one "abc" job on u_full; cycle numbers count from the start sample (cycle 0).
    task automatic run_abc(input bit stall_alt, input int restart_at, input int max_cyc, input bit stop_at_done,
                           output int first_done, output int n_done, output int stalls, output logic [255:0] dig);
        int  tt, c;
        logic a;
        tt = 0; first_done = -1; n_done = 0; stalls = 0; dig = '0;
        h_in0 = H0; start0 = 1'b1; win_valid0 = 1'b0;
        tick();
        start0 = 1'b0; c = 1;
        chk("busy_ready_after_start", {30'd0, busy0, win_ready0}, 32'd3);
        while (c < max_cyc) begin
            if (done0) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = c;
                    dig = digest0;
                    chk("busy_low_at_done", {31'd0, busy0}, 32'd0);
                end
                if (stop_at_done) break;
            end
            win_valid0 = (tt < 64) && !(stall_alt && (c % 2 == 0));
            win_in0    = {w_abc[tt < 64 ? tt : 0], FILLER};
            start0     = (c == restart_at);
            if (win_ready0 && !win_valid0) stalls++;
            a = win_valid0 && win_ready0;
            tick();
            c++;
            if (a) tt++;
        end
        win_valid0 = 1'b0;
        start0 = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; gcyc = 0;
        RST = 1'b0;
        start0 = 1'b0; win_valid0 = 1'b0; win_in0 = '0; h_in0 = '0;
        start1 = 1'b0; win_valid1 = 1'b0; win_in1 = '0; h_in1 = '0;

        for (int i = 0; i < 16; i++) w_abc[i] = 32'h0;
        w_abc[0]  = 32'h61626380;
        w_abc[15] = 32'h00000018;
        for (int i = 16; i < 64; i++) begin
            w_abc[i] = (rr(w_abc[i-2], 17) ^ rr(w_abc[i-2], 19) ^ (w_abc[i-2] >> 10)) + w_abc[i-7]
                     + (rr(w_abc[i-15], 7) ^ rr(w_abc[i-15], 18) ^ (w_abc[i-15] >> 3)) + w_abc[i-16];
        end
`ifdef SHA256_FEEDFORWARD_EN
        exp_abc = ABC_DIGEST;
`else
        exp_abc = add8(ABC_DIGEST, H0, 1'b1);
`endif
        st = H0;
        for (int i = 0; i < 32; i++) st = ref_round(st, K[i], w_abc[i]);
        st32 = st;
        for (int i = 32; i <= 56; i++) st = ref_round(st, K[i], w_abc[i]);
`ifdef SHA256_FEEDFORWARD_EN
        exp_seg = add8(st, st32, 1'b0);
`else
        exp_seg = st;
`endif

        repeat (2) tick();
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_win_ready", {31'd0, win_ready0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_digest", digest0, 256'd0);
        chk("rst_round_idx_full", {26'd0, round_idx0}, 32'd0);
        chk("rst_round_idx_seg", {26'd0, round_idx1}, 32'd32);
        RST = 1'b1;
        tick();

        run_abc(1'b0, -1, 70, 1'b0, fd, nd, ns, dg);
        chk("abc_done_cycle", fd, 65);
        chk("abc_done_count", nd, 1);
        chk("abc_digest_at_done", dg, exp_abc);
        chk("abc_digest_held", digest0, exp_abc);

        run_abc(1'b1, -1, 135, 1'b0, fd, nd, ns, dg);
        chk("stall_count", ns, 63);
        chk("stall_done_cycle", fd, 128);
        chk("stall_done_vs_stalls", fd, 65 + ns);
        chk("stall_digest", dg, exp_abc);

        run_abc(1'b0, 10, 72, 1'b0, fd, nd, ns, dg);
        chk("restart_done_cycle", fd, 65);
        chk("restart_done_count", nd, 1);
        chk("restart_digest", digest0, exp_abc);

        run_abc(1'b0, -1, 21, 1'b0, fd, nd, ns, dg);
        chk("abort_round_idx_before", {26'd0, round_idx0}, 32'd20);
        RST = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_win_ready", {31'd0, win_ready0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_digest", digest0, 256'd0);
        chk("abort_round_idx", {26'd0, round_idx0}, 32'd0);
        repeat (2) tick();
        RST = 1'b1;
        n1 = 0;
        for (int i = 0; i < 70; i++) begin
            if (done0) n1++;
            tick();
        end
        chk("abort_no_done", n1, 0);
        run_abc(1'b0, -1, 68, 1'b0, fd, nd, ns, dg);
        chk("post_abort_done_cycle", fd, 65);
        chk("post_abort_digest", dg, exp_abc);

        run_abc(1'b0, -1, 70, 1'b1, fd, nd, ns, dg);
        d1 = gcyc;
        chk("b2b_first_digest", dg, exp_abc);
        tick();
        run_abc(1'b0, -1, 70, 1'b1, fd, nd, ns, dg);
        d2 = gcyc;
        chk("b2b_second_done_seen", nd, 1);
        chk("b2b_done_spacing", d2 - d1, 66);
        chk("b2b_second_digest", dg, exp_abc);

        h_in1 = st32; start1 = 1'b1;
        tick();
        start1 = 1'b0; cyc = 1; t = 32; n1 = 0; fd = -1; dg = '0;
        while (cyc < 32) begin
            if (done1) begin
                n1++;
                if (fd < 0) begin
                    fd = cyc;
                    dg = digest1;
                end
            end
            win_valid1 = (t <= 56);
            win_in1    = {w_abc[t <= 56 ? t : 0], FILLER};
            acc = win_valid1 && win_ready1;
            tick();
            cyc++;
            if (acc) t++;
        end
        win_valid1 = 1'b0;
        chk("seg_done_cycle", fd, 26);
        chk("seg_done_count", n1, 1);
        chk("seg_digest", dg, exp_seg);
        chk("seg_round_idx_end", {26'd0, round_idx1}, 32'd56);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
